// File: rtl/pll_seq_pkg.sv
// Shared types and defaults for the PLL reset sequencer: state encoding,
// default timing constants and the internal cycle-counter width helper.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_FILTER    = 3'd2,
    ST_HOLD      = 3'd3,
    ST_RUN       = 3'd4
  } pll_state_e;

  localparam int DEF_RST_CYCLES       = 10;
  localparam int DEF_LOCK_TIMEOUT     = 50000;
  localparam int DEF_LOCK_FILTER      = 1000;
  localparam int DEF_POST_LOCK_CYCLES = 16;
  localparam int DEF_CNT_W            = 8;

  // One counter is shared by every state, so it is sized for the longest wait.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer with asynchronous active-high reset; output is the
// input delayed by two clock edges.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer on refclk: pulses pll_rst, waits for a filtered lock,
// then releases sys_rst. Optional macro PLLSEQ_MANUAL_RESTART_EN adds restart_req.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES       = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT     = DEF_LOCK_TIMEOUT,
  parameter int LOCK_FILTER      = DEF_LOCK_FILTER,
  parameter int POST_LOCK_CYCLES = DEF_POST_LOCK_CYCLES,
  parameter int CNT_W            = DEF_CNT_W
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             pll_locked,
`ifdef PLLSEQ_MANUAL_RESTART_EN
  input  logic             restart_req,
`endif
  output logic             pll_rst,
  output logic             sys_rst,
  output logic             ready,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] timeout_cnt,
  output logic [CNT_W-1:0] relock_cnt
);

  localparam int TW = cnt_width(RST_CYCLES, LOCK_TIMEOUT, LOCK_FILTER, POST_LOCK_CYCLES);

  localparam logic [TW-1:0]    RST_LAST  = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0]    TO_LAST   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0]    FILT_LAST = TW'(LOCK_FILTER - 1);
  localparam logic [TW-1:0]    POST_LAST = TW'(POST_LOCK_CYCLES - 1);
  localparam logic [TW-1:0]    CNT_INC   = TW'(1);
  localparam logic [CNT_W-1:0] EVT_INC   = CNT_W'(1);

  pll_state_e       r_state;
  logic [TW-1:0]    r_cnt;
  logic             r_pll_rst;
  logic             r_sys_rst;
  logic             r_ready;
  logic [CNT_W-1:0] r_timeout_cnt;
  logic [CNT_W-1:0] r_relock_cnt;

  logic       w_lock_s;
  logic       w_restart;
  pll_state_e w_next;
  logic       w_timeout_evt;
  logic       w_relock_evt;
  logic       w_cnt_clr;

  sync_2ff u_lock_sync (
    .i_clk (refclk),
    .i_rst (rst),
    .i_d   (pll_locked),
    .o_q   (w_lock_s)
  );

`ifdef PLLSEQ_MANUAL_RESTART_EN
  assign w_restart = restart_req;
`else
  assign w_restart = 1'b0;
`endif

  always_comb begin
    w_next        = r_state;
    w_timeout_evt = 1'b0;
    w_relock_evt  = 1'b0;
    case (r_state)
      ST_RESET_PLL: begin
        if (r_cnt == RST_LAST) w_next = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        // A lock arriving on the timeout cycle is taken rather than retried.
        if (w_lock_s) begin
          w_next = ST_FILTER;
        end else if (r_cnt == TO_LAST) begin
          w_next        = ST_RESET_PLL;
          w_timeout_evt = 1'b1;
        end
      end
      ST_FILTER: begin
        if (!w_lock_s)              w_next = ST_WAIT_LOCK;
        else if (r_cnt == FILT_LAST) w_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (!w_lock_s)              w_next = ST_WAIT_LOCK;
        else if (r_cnt == POST_LAST) w_next = ST_RUN;
      end
      ST_RUN: begin
        if (!w_lock_s) begin
          w_next       = ST_RESET_PLL;
          w_relock_evt = 1'b1;
        end
      end
      default: w_next = ST_RESET_PLL;
    endcase
    if (w_restart) begin
      w_next        = ST_RESET_PLL;
      w_timeout_evt = 1'b0;
      w_relock_evt  = 1'b0;
    end
  end

  // A restart while already in RESET_PLL re-arms the full reset pulse.
  assign w_cnt_clr = (w_next != r_state) || w_restart;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_RESET_PLL;
      r_cnt         <= '0;
      r_pll_rst     <= 1'b1;
      r_sys_rst     <= 1'b1;
      r_ready       <= 1'b0;
      r_timeout_cnt <= '0;
      r_relock_cnt  <= '0;
    end else begin
      r_state   <= w_next;
      r_cnt     <= w_cnt_clr ? '0 : r_cnt + CNT_INC;
      r_pll_rst <= (w_next == ST_RESET_PLL);
      r_sys_rst <= (w_next != ST_RUN);
      r_ready   <= (w_next == ST_RUN);
      if (w_timeout_evt && (r_timeout_cnt != '1)) r_timeout_cnt <= r_timeout_cnt + EVT_INC;
      if (w_relock_evt && (r_relock_cnt != '1))   r_relock_cnt  <= r_relock_cnt + EVT_INC;
    end
  end

  assign pll_rst     = r_pll_rst;
  assign sys_rst     = r_sys_rst;
  assign ready       = r_ready;
  assign state_o     = r_state;
  assign timeout_cnt = r_timeout_cnt;
  assign relock_cnt  = r_relock_cnt;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer with a phase/age reference model;
// define PLLSEQ_MANUAL_RESTART_EN to also cover restart_req.
module tb_pll_reset_sequencer;

  localparam int RST_C  = 4;
  localparam int TO_C   = 32;
  localparam int FILT_C = 8;
  localparam int POST_C = 4;
  localparam int CW     = 4;
  localparam int MAXC   = (1 << CW) - 1;
  localparam logic [13:0] RESET_VEC = {3'd0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0};

  logic          refclk;
  logic          rst;
  logic          pll_locked;
`ifdef PLLSEQ_MANUAL_RESTART_EN
  logic          restart_req;
`endif
  logic          pll_rst;
  logic          sys_rst;
  logic          ready;
  logic [2:0]    state_o;
  logic [CW-1:0] timeout_cnt;
  logic [CW-1:0] relock_cnt;

  int total;
  int bad;
  logic [2:0] exp_q[$];
  logic [2:0] seen_q[$];

  pll_reset_sequencer #(
    .RST_CYCLES       (RST_C),
    .LOCK_TIMEOUT     (TO_C),
    .LOCK_FILTER      (FILT_C),
    .POST_LOCK_CYCLES (POST_C),
    .CNT_W            (CW)
  ) dut (
    .refclk      (refclk),
    .rst         (rst),
    .pll_locked  (pll_locked),
`ifdef PLLSEQ_MANUAL_RESTART_EN
    .restart_req (restart_req),
`endif
    .pll_rst     (pll_rst),
    .sys_rst     (sys_rst),
    .ready       (ready),
    .state_o     (state_o),
    .timeout_cnt (timeout_cnt),
    .relock_cnt  (relock_cnt)
  );

  initial refclk = 1'b0;
  always #10 refclk = ~refclk;

  // Reference model: phase number, cycles spent in it, and the lock level two edges back.
  int         m_phase;
  int         m_age;
  int         m_tcnt;
  int         m_rcnt;
  int         m_next;
  logic [1:0] m_hist;
  logic       m_rq;

`ifdef PLLSEQ_MANUAL_RESTART_EN
  assign m_rq = restart_req;
`else
  assign m_rq = 1'b0;
`endif

  function automatic int next_phase(int p, int age, logic ls, logic rq);
    if (rq) return 0;
    case (p)
      0: return (age + 1 >= RST_C) ? 1 : 0;
      1: begin
        if (ls) return 2;
        return (age + 1 >= TO_C) ? 0 : 1;
      end
      2: begin
        if (!ls) return 1;
        return (age + 1 >= FILT_C) ? 3 : 2;
      end
      3: begin
        if (!ls) return 1;
        return (age + 1 >= POST_C) ? 4 : 3;
      end
      default: return ls ? 4 : 0;
    endcase
  endfunction

  assign m_next = next_phase(m_phase, m_age, m_hist[1], m_rq);

  always @(posedge refclk or posedge rst) begin
    if (rst) begin
      m_phase <= 0;
      m_age   <= 0;
      m_tcnt  <= 0;
      m_rcnt  <= 0;
      m_hist  <= 2'b00;
    end else begin
      m_hist  <= {m_hist[0], pll_locked};
      m_phase <= m_next;
      m_age   <= (m_rq || (m_next != m_phase)) ? 0 : m_age + 1;
      if (!m_rq && (m_phase == 1) && (m_next == 0) && (m_tcnt < MAXC)) m_tcnt <= m_tcnt + 1;
      if (!m_rq && (m_phase == 4) && (m_next == 0) && (m_rcnt < MAXC)) m_rcnt <= m_rcnt + 1;
    end
  end

  function automatic logic [13:0] exp_vec();
    return {3'(m_phase), (m_phase == 0), (m_phase != 4), (m_phase == 4), CW'(m_tcnt), CW'(m_rcnt)};
  endfunction

  logic [13:0] dut_vec;
  assign dut_vec = {state_o, pll_rst, sys_rst, ready, timeout_cnt, relock_cnt};

  // Pulse rst across one clock edge; returns at the negedge where rst is released.
  task automatic do_reset();
    @(negedge refclk);
    rst        = 1'b1;
    pll_locked = 1'b0;
    @(negedge refclk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #5 rst = 1'b1;
    #2;
    total++;
    if (dut_vec !== RESET_VEC) begin
      bad++;
      $display("FAIL reset_values: got %h want %h", dut_vec, RESET_VEC);
    end
    @(negedge refclk);
    @(negedge refclk);
    total++;
    if (dut_vec !== RESET_VEC) begin
      bad++;
      $display("FAIL reset_held: got %h want %h", dut_vec, RESET_VEC);
    end
    rst = 1'b0;
  endtask

  task automatic test_bring_up();
    int hi;
    int lat;
    do_reset();
    seen_q = {};
    seen_q.push_back(state_o);
    hi = 0;
    for (int k = 0; k < 50; k++) begin
      if (pll_rst !== 1'b1) break;
      hi++;
      @(negedge refclk);
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++;
        $display("FAIL bring_up_model t=%0t: got %h want %h", $time, dut_vec, exp_vec());
      end
      if (state_o !== seen_q[$]) seen_q.push_back(state_o);
    end
    total++;
    if (hi != RST_C) begin
      bad++;
      $display("FAIL bring_up_pll_rst_width: got %0d want %0d", hi, RST_C);
    end
    repeat (10) begin
      @(negedge refclk);
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++;
        $display("FAIL bring_up_model t=%0t: got %h want %h", $time, dut_vec, exp_vec());
      end
      if (state_o !== seen_q[$]) seen_q.push_back(state_o);
    end
    pll_locked = 1'b1;
    lat = 0;
    while ((ready !== 1'b1) && (lat < 100)) begin
      @(negedge refclk);
      lat++;
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++;
        $display("FAIL bring_up_model t=%0t: got %h want %h", $time, dut_vec, exp_vec());
      end
      if (state_o !== seen_q[$]) seen_q.push_back(state_o);
    end
    total++;
    if ((lat < 2 + FILT_C + POST_C - 1) || (lat > 2 + FILT_C + POST_C + 1)) begin
      bad++;
      $display("FAIL bring_up_latency: got %0d want %0d..%0d", lat, 2 + FILT_C + POST_C - 1, 2 + FILT_C + POST_C + 1);
    end
    total++;
    if ((ready !== 1'b1) || (sys_rst !== 1'b0)) begin
      bad++;
      $display("FAIL bring_up_released: got ready=%b sys_rst=%b want ready=1 sys_rst=0", ready, sys_rst);
    end
    exp_q = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    total++;
    if (seen_q != exp_q) begin
      bad++;
      $display("FAIL bring_up_sequence: got %p want %p", seen_q, exp_q);
    end
  endtask

  task automatic test_lock_loss();
    int n;
    int hi;
    repeat (5) begin
      @(negedge refclk);
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++;
        $display("FAIL lock_loss_model t=%0t: got %h want %h", $time, dut_vec, exp_vec());
      end
    end
    pll_locked = 1'b0;
    n = 0;
    while ((state_o !== 3'd0) && (n < 20)) begin
      @(negedge refclk);
      n++;
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++;
        $display("FAIL lock_loss_model t=%0t: got %h want %h", $time, dut_vec, exp_vec());
      end
    end
    total++;
    if ((n < 2) || (n > 3)) begin
      bad++;
      $display("FAIL lock_loss_delay: got %0d want 2..3", n);
    end
    hi = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge refclk);
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++;
        $display("FAIL lock_loss_model t=%0t: got %h want %h", $time, dut_vec, exp_vec());
      end
      if (k == 0) begin
        total++;
        if ({sys_rst, ready, relock_cnt} !== {1'b1, 1'b0, 4'd1}) begin
          bad++;
          $display("FAIL lock_loss_outputs: got sys_rst=%b ready=%b relock=%0d want 1 0 1", sys_rst, ready, relock_cnt);
        end
      end
      if (pll_rst !== 1'b1) break;
      hi++;
    end
    total++;
    if (hi != RST_C) begin
      bad++;
      $display("FAIL lock_loss_pll_rst_width: got %0d want %0d", hi, RST_C);
    end
    pll_locked = 1'b1;
    n = 0;
    while ((ready !== 1'b1) && (n < 60)) begin
      @(negedge refclk);
      n++;
    end
    total++;
    if ({ready, relock_cnt} !== {1'b1, 4'd1}) begin
      bad++;
      $display("FAIL lock_loss_relock: got ready=%b relock=%0d want 1 1", ready, relock_cnt);
    end
  endtask

  task automatic test_timeout();
    int period;
    period = RST_C + TO_C;
    do_reset();
    for (int k = 1; k <= period * 18; k++) begin
      @(negedge refclk);
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++;
        $display("FAIL timeout_model t=%0t: got %h want %h", $time, dut_vec, exp_vec());
      end
      if (k == period - 1) begin
        total++;
        if ({state_o, timeout_cnt} !== {3'd1, 4'd0}) begin
          bad++;
          $display("FAIL timeout_before: got state=%0d cnt=%0d want 1 0", state_o, timeout_cnt);
        end
      end
      if (k == period) begin
        total++;
        if ({state_o, pll_rst, timeout_cnt} !== {3'd0, 1'b1, 4'd1}) begin
          bad++;
          $display("FAIL timeout_first: got state=%0d pll_rst=%b cnt=%0d want 0 1 1", state_o, pll_rst, timeout_cnt);
        end
      end
      if (k == period * 16) begin
        total++;
        if (timeout_cnt !== 4'd15) begin
          bad++;
          $display("FAIL timeout_sixteen: got %0d want 15", timeout_cnt);
        end
      end
    end
    total++;
    if (timeout_cnt !== 4'd15) begin
      bad++;
      $display("FAIL timeout_saturate: got %0d want 15", timeout_cnt);
    end
  endtask

  task automatic test_glitch();
    int n;
    int early;
    do_reset();
    n = 0;
    while ((pll_rst !== 1'b0) && (n < 20)) begin
      @(negedge refclk);
      n++;
    end
    repeat (3) @(negedge refclk);
    seen_q = {};
    seen_q.push_back(state_o);
    early = 0;
    for (int k = 0; k < 80; k++) begin
      if (k < 5)       pll_locked = 1'b1;
      else if (k == 5) pll_locked = 1'b0;
      else             pll_locked = 1'b1;
      @(negedge refclk);
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++;
        $display("FAIL glitch_model t=%0t: got %h want %h", $time, dut_vec, exp_vec());
      end
      if ((sys_rst !== 1'b1) && (state_o !== 3'd4)) early++;
      if (state_o !== seen_q[$]) seen_q.push_back(state_o);
      if (ready === 1'b1) break;
    end
    exp_q = {3'd1, 3'd2, 3'd1, 3'd2, 3'd3, 3'd4};
    total++;
    if (seen_q != exp_q) begin
      bad++;
      $display("FAIL glitch_sequence: got %p want %p", seen_q, exp_q);
    end
    total++;
    if (early != 0) begin
      bad++;
      $display("FAIL glitch_early_release: got %0d cycles want 0", early);
    end
  endtask

  task automatic test_async_mid_filter();
    int n;
    do_reset();
    repeat (RST_C + TO_C) @(negedge refclk);
    pll_locked = 1'b1;
    n = 0;
    while ((state_o !== 3'd2) && (n < 30)) begin
      @(negedge refclk);
      n++;
    end
    total++;
    if ({state_o, timeout_cnt} !== {3'd2, 4'd1}) begin
      bad++;
      $display("FAIL async_reach_filter: got state=%0d cnt=%0d want 2 1", state_o, timeout_cnt);
    end
    #3 rst = 1'b1;
    #2;
    total++;
    if (dut_vec !== RESET_VEC) begin
      bad++;
      $display("FAIL async_reset_immediate: got %h want %h", dut_vec, RESET_VEC);
    end
    #2 rst = 1'b0;
    repeat (12) begin
      @(negedge refclk);
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++;
        $display("FAIL async_after_model t=%0t: got %h want %h", $time, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    int run;
    logic lvl;
    do_reset();
    run = 0;
    lvl = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      @(negedge refclk);
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++;
        $display("FAIL random_model t=%0t: got %h want %h", $time, dut_vec, exp_vec());
      end
      if (run == 0) begin
        lvl = ($urandom_range(0, 3) != 0);
        run = lvl ? $urandom_range(1, 40) : $urandom_range(1, 45);
      end
      pll_locked = lvl;
      run--;
`ifdef PLLSEQ_MANUAL_RESTART_EN
      restart_req = ($urandom_range(0, 199) == 0);
`endif
    end
`ifdef PLLSEQ_MANUAL_RESTART_EN
    restart_req = 1'b0;
`endif
  endtask

`ifdef PLLSEQ_MANUAL_RESTART_EN
  task automatic test_restart();
    int n;
    logic [CW-1:0] rc;
    do_reset();
    pll_locked = 1'b1;
    n = 0;
    while ((ready !== 1'b1) && (n < 60)) begin
      @(negedge refclk);
      n++;
    end
    rc = relock_cnt;
    restart_req = 1'b1;
    @(negedge refclk);
    restart_req = 1'b0;
    total++;
    if ({state_o, pll_rst, ready, relock_cnt, timeout_cnt} !== {3'd0, 1'b1, 1'b0, rc, 4'd0}) begin
      bad++;
      $display("FAIL restart_forced: got state=%0d pll_rst=%b ready=%b relock=%0d want 0 1 0 %0d", state_o, pll_rst, ready, relock_cnt, rc);
    end
    n = 0;
    while ((ready !== 1'b1) && (n < 60)) begin
      @(negedge refclk);
      n++;
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++;
        $display("FAIL restart_model t=%0t: got %h want %h", $time, dut_vec, exp_vec());
      end
    end
    total++;
    if (ready !== 1'b1) begin
      bad++;
      $display("FAIL restart_relock: got ready=%b want 1", ready);
    end
  endtask
`endif

  initial begin
    total      = 0;
    bad        = 0;
    rst        = 1'b0;
    pll_locked = 1'b0;
`ifdef PLLSEQ_MANUAL_RESTART_EN
    restart_req = 1'b0;
`endif
    test_reset();
    test_bring_up();
    test_lock_loss();
    test_timeout();
    test_glitch();
    test_async_mid_filter();
    test_random();
`ifdef PLLSEQ_MANUAL_RESTART_EN
    test_restart();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Sequences the board PLL's reset and lock handshake from the free-running 50 MHz reference clock.
- Holds the PLL in reset for a minimum pulse, then waits for `locked` within a timeout and filters `locked` for stability.
- Releases the system reset only after lock is stable. Re-sequences automatically on lock loss or timeout.
- Sits between the top-level reset pin, the PLL wrapper and the CPU core reset tree.

Parameters:
- RST_CYCLES, 10: cycles pll_rst is held high per attempt (200 ns at 50 MHz).
- LOCK_TIMEOUT, 50000: cycles allowed in WAIT_LOCK before retry (1 ms).
- LOCK_FILTER, 1000: consecutive synchronized-locked cycles required.
- POST_LOCK_CYCLES, 16: extra cycles sys_rst stays high after the filter passes.
- CNT_W, 8: width of the saturating event counters.

Ports:
- refclk, in, 1: reference clock, free-running; all logic is on this clock.
- rst, in, 1: asynchronous active-high reset.
- pll_locked, in, 1: PLL locked output; asynchronous to refclk.
- pll_rst, out, 1: drives the PLL rst input.
- sys_rst, out, 1: active-high system reset request; downstream re-synchronizes it into the outclk domain.
- ready, out, 1: 1 only in RUN.
- state_o, out, 3: current state encoding.
- timeout_cnt, out, CNT_W: saturating count of lock timeouts.
- relock_cnt, out, CNT_W: saturating count of lock losses from RUN.

Behaviour:
- Clock and reset: one clock (refclk); reset is asynchronous and active-high (rst).
- Reset values (rst high, asynchronously):
  - state = RESET_PLL, pll_rst = 1, sys_rst = 1, ready = 0.
  - timeout_cnt = 0, relock_cnt = 0, internal cycle counter = 0, synchronizer flops = 0.
- pll_locked synchronizer: 2-FF, giving lock_s. Latency from pll_locked to lock_s is 2 refclk edges.
- All outputs are registered. Outputs change on the edge that enters the new state.
- Single shared cycle counter. It is cleared on every state transition.
- State encoding: RESET_PLL = 0, WAIT_LOCK = 1, FILTER = 2, HOLD = 3, RUN = 4.
- RESET_PLL:
  - pll_rst = 1, sys_rst = 1.
  - After RST_CYCLES cycles in the state, go to WAIT_LOCK.
- WAIT_LOCK:
  - pll_rst = 0.
  - lock_s = 1 → FILTER.
  - Otherwise, when the counter reaches LOCK_TIMEOUT−1 → RESET_PLL and timeout_cnt +1.
  - If lock_s rises on the same cycle as the timeout, lock_s wins.
- FILTER:
  - lock_s = 0 on any cycle → WAIT_LOCK. This restarts the full timeout.
  - LOCK_FILTER consecutive cycles with lock_s = 1 → HOLD.
- HOLD:
  - sys_rst still 1.
  - lock_s = 0 → WAIT_LOCK.
  - After POST_LOCK_CYCLES cycles → RUN.
- RUN:
  - sys_rst = 0, ready = 1.
  - lock_s = 0 → RESET_PLL, relock_cnt +1. sys_rst = 1 and ready = 0 from the next edge.
- Counters: timeout_cnt and relock_cnt saturate at 2^CNT_W−1 and never wrap. They are cleared only by rst.
- Reset mid-operation: rst asserted in any state forces the reset values immediately. Sequencing restarts from RESET_PLL when rst deasserts.
- Internal counter width: clog2 of max(RST_CYCLES, LOCK_TIMEOUT, LOCK_FILTER, POST_LOCK_CYCLES) + 1.

Optional Feature:
- Macro: PLLSEQ_MANUAL_RESTART_EN.
- Defined:
  - Adds input restart_req (1 bit, synchronous to refclk).
  - A 1 on restart_req in any state except RESET_PLL forces RESET_PLL on the next edge.
  - The forced restart does not increment any counter.
  - In RESET_PLL, restart_req restarts the RST_CYCLES count.
- Undefined: the port is absent and behaviour is exactly as above.

Decomposition:
- Shared package pll_seq_pkg:
  - state enum type and its 3-bit encoding.
  - default parameter constants.
  - counter-width helper function.
- One sub-module, sync_2ff: reusable 2-flop synchronizer with async active-high reset, used for pll_locked.

Test Plan (RST_CYCLES=4, LOCK_TIMEOUT=32, LOCK_FILTER=8, POST_LOCK_CYCLES=4, CNT_W=4):
1. Normal bring-up:
   - Stimulus: release rst; pll_locked rises 10 cycles after pll_rst falls.
   - Response: pll_rst high for exactly 4 cycles. sys_rst falls and ready rises 2+8+4 cycles after pll_locked rises (±1 edge for entry). state_o goes 0→1→2→3→4.
2. Timeout:
   - Stimulus: hold pll_locked = 0.
   - Response: after 4+32 cycles, back to RESET_PLL with timeout_cnt = 1. After 16 such attempts timeout_cnt stays 15.
3. Glitchy lock:
   - Stimulus: pll_locked high 5 cycles, low 1, high.
   - Response: FILTER→WAIT_LOCK→FILTER; HOLD is entered only after 8 clean cycles; sys_rst never deasserts early.
4. Lock loss in RUN:
   - Stimulus: drop pll_locked in RUN.
   - Response: 2 cycles later state = RESET_PLL, then on the next edge sys_rst = 1, ready = 0, relock_cnt = 1, pll_rst = 1 for 4 cycles.
5. Async reset mid-FILTER:
   - Stimulus: pulse rst for a fraction of a cycle.
   - Response: all outputs take their reset values immediately (no clock edge needed); counters return to 0.
6. PLLSEQ_MANUAL_RESTART_EN:
   - Stimulus: restart_req = 1 for 1 cycle in RUN.
   - Response: RESET_PLL on the next edge; relock_cnt unchanged; normal re-lock follows.
